// File: rtl/binary_down_counter_if.sv
// Control/status bundle for the loadable binary down counter.
// The master drives load/data/enable/mode; the counter (slave) returns count and flags.
interface binary_down_counter_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data_in;
    logic             load;
    logic             enable;
    logic             mode;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             tc;
    logic             busy;

    modport master (
        output data_in, load, enable, mode,
        input  count, zero, tc, busy
    );

    modport slave (
        input  data_in, load, enable, mode,
        output count, zero, tc, busy
    );
endinterface

// File: rtl/binary_down_counter.sv
// Loadable down counter: counts a loaded value to zero, then stops (one-shot)
// or reloads itself (periodic), pulsing tc for one cycle on each 1->0 step.
module binary_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    binary_down_counter_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q,   mode_d;
    logic             tc_q,     tc_d;

    // NOTE: every next-state signal gets its hold/default value first so no path
    // through the decision tree can leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        tc_d     = 1'b0;

        if (bus.load) begin
            count_d  = bus.data_in;
            reload_d = bus.data_in;
            mode_d   = bus.mode;
            state_d  = (bus.data_in != '0) ? RUN : IDLE;
        end else if (state_q == RUN && bus.enable) begin
            if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
            end else if (count_q == WIDTH'(1)) begin
                count_d = '0;
                tc_d    = 1'b1;
                if (!mode_q) begin
                    state_d = IDLE;
                end
            end else begin
                // Zero while running only happens in periodic mode: wrap to the reload value.
                count_d = reload_q;
            end
        end
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than
    // the sensitivity list; all state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            tc_q     <= tc_d;
        end
    end

    assign bus.count = count_q;
    assign bus.zero  = (count_q == '0);
    assign bus.tc    = tc_q;
    assign bus.busy  = (state_q == RUN);
endmodule

// File: tb/tb_binary_down_counter.sv
// Directed self-checking bench for binary_down_counter (WIDTH=4) with
// hand-computed expected values.
module tb_binary_down_counter;
    localparam int WIDTH = 4;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   tc_pulses;

    binary_down_counter_if #(.WIDTH(WIDTH)) bus ();

    binary_down_counter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int c, input bit z, input bit t, input bit b);
        check({tag, ".count"}, 32'(bus.count), 32'(c));
        check({tag, ".zero"},  32'(bus.zero),  32'(z));
        check({tag, ".tc"},    32'(bus.tc),    32'(t));
        check({tag, ".busy"},  32'(bus.busy),  32'(b));
    endtask

    initial begin
        int exp_seq[8] = '{2, 1, 0, 3, 2, 1, 0, 3};
        int k;
        total = 0;
        bad   = 0;

        // Reset, then enable alone must not start anything.
        reset = 1'b1; bus.load = 1'b0; bus.enable = 1'b0; bus.mode = 1'b0; bus.data_in = '0;
        tick();
        reset = 1'b0;
        check_all("reset", 0, 1, 0, 0);
        bus.enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all("idle_hold", 0, 1, 0, 0);
        end

        // One-shot from 13.
        bus.load = 1'b1; bus.data_in = 4'd13; bus.mode = 1'b0;
        tick();
        bus.load = 1'b0;
        check_all("os_load", 13, 0, 0, 1);
        for (int i = 12; i >= 0; i--) begin
            tick();
            check_all("os_step", i, i == 0, i == 0, i != 0);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            check_all("os_after", 0, 1, 0, 0);
        end

        // Periodic from 3 with enable toggling 1,0,1,0...
        bus.load = 1'b1; bus.data_in = 4'd3; bus.mode = 1'b1;
        tick();
        bus.load = 1'b0;
        bus.mode = 1'b0;
        check_all("per_load", 3, 0, 0, 1);
        tc_pulses = 0;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            bus.enable = (i % 2 == 0);
            tick();
            if (i % 2 == 0) begin
                check_all("per_run", exp_seq[k], exp_seq[k] == 0, exp_seq[k] == 0, 1);
                k++;
            end else begin
                check_all("per_stall", exp_seq[k-1], exp_seq[k-1] == 0, 0, 1);
            end
            if (bus.tc) tc_pulses++;
        end
        check("per_tc_pulses", 32'(tc_pulses), 32'd2);

        // Reload mid-run: 13 down to 9, then load 5 one-shot.
        bus.enable = 1'b1;
        bus.load = 1'b1; bus.data_in = 4'd13; bus.mode = 1'b0;
        tick();
        bus.load = 1'b0;
        check_all("rl_load13", 13, 0, 0, 1);
        for (int i = 0; i < 4; i++) tick();
        check_all("rl_at9", 9, 0, 0, 1);
        bus.load = 1'b1; bus.data_in = 4'd5;
        tick();
        bus.load = 1'b0;
        check_all("rl_load5", 5, 0, 0, 1);
        for (int i = 4; i >= 0; i--) begin
            tick();
            check_all("rl_step", i, i == 0, i == 0, i != 0);
        end

        // Zero load, then load colliding with terminal edge.
        bus.load = 1'b1; bus.data_in = 4'd0;
        tick();
        check_all("zero_load", 0, 1, 0, 0);
        bus.data_in = 4'd2;
        tick();
        bus.load = 1'b0;
        check_all("col_load2", 2, 0, 0, 1);
        tick();
        check_all("col_at1", 1, 0, 0, 1);
        bus.load = 1'b1; bus.data_in = 4'd7;
        tick();
        bus.load = 1'b0;
        check_all("col_load7", 7, 0, 0, 1);

        // Reset mid-run overrides load and enable.
        bus.load = 1'b1; bus.data_in = 4'd15; bus.mode = 1'b1;
        tick();
        bus.load = 1'b0;
        check_all("rst_load15", 15, 0, 0, 1);
        for (int i = 0; i < 9; i++) tick();
        check_all("rst_at6", 6, 0, 0, 1);
        reset = 1'b1; bus.load = 1'b1; bus.data_in = 4'd9;
        tick();
        reset = 1'b0; bus.load = 1'b0;
        check_all("rst_mid", 0, 1, 0, 0);
        tick();
        check_all("rst_after", 0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/binary_down_counter.md
Name: binary_down_counter

Overview:
- Loadable binary down counter, the counting-direction complement of the team's binary up counter; shares the clk/reset/load/data_in/count interface style.
- Counts a loaded value down to zero and then either stops (one-shot) or reloads itself (periodic).
- Flags terminal count with a single-cycle pulse.
- Used as a programmable delay or interval timer alongside the up counter.

Parameters:
- WIDTH, 4, bit width of data_in, count and the internal reload register.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  load value, sampled when load=1.
- load  input  1  load strobe; loads count and the reload register and samples mode.
- enable  input  1  count enable; when low, count holds.
- mode  input  1  sampled only on load: 0 = one-shot, 1 = periodic auto-reload.
- count  output  WIDTH  current count, registered.
- zero  output  1  high when count == 0; combinational decode of the count register.
- tc  output  1  terminal-count pulse, registered, high for exactly one cycle.
- busy  output  1  high while in state RUN, registered.

Behaviour:
- Clocking: single clock domain. Decision priority each rising edge: reset > load > count/enable.
- Reset (reset=1 at an edge):
  - count=0, reload_reg=0, mode_reg=0, tc=0, busy=0, state=IDLE. zero therefore reads 1.
  - Reset mid-count aborts immediately with no tc pulse.
- States:
  - IDLE: holds count; enable is ignored.
  - RUN: counts down while enable=1.
- Load (load=1, reset=0):
  - Effects: count<=data_in, reload_reg<=data_in, mode_reg<=mode, tc<=0.
  - If data_in != 0: state<=RUN, busy<=1.
  - If data_in == 0: state<=IDLE, busy<=0, no tc pulse.
  - A load during RUN restarts the count from the new value. No tc is generated for the aborted run, even if that same edge would have reached zero.
  - enable has no effect on a load cycle.
  - Latency: the new count is visible on the cycle after the load edge. The first decrement occurs on the next enabled edge after that.
- RUN with enable=1:
  - count > 1: count<=count-1, tc<=0.
  - count == 1: count<=0 and tc<=1, both on the same edge, so tc and zero rise together.
    - One-shot (mode_reg=0): state<=IDLE, busy<=0.
    - Periodic (mode_reg=1): remain in RUN.
  - count == 0, reachable only in periodic mode: count<=reload_reg, tc<=0.
  - Periodic sequence: N, N-1, ..., 1, 0, N, ... with a period of N+1 enabled cycles and one tc pulse per period.
- RUN with enable=0:
  - count and state hold; tc<=0.
  - A stall never stretches or repeats tc.
- tc is deasserted on every edge where no count 1->0 transition occurs.
- No underflow: count never wraps below 0 in either mode. Arithmetic is unsigned WIDTH-bit.
- Maximum load value 2^WIDTH-1 is legal. Its periodic period is 2^WIDTH enabled cycles.
- The mode input is ignored except on load edges; changing it mid-run has no effect.
- There are no X outputs after the first reset edge.

Test Plan (WIDTH=4):
- Reset then hold -> after the reset edge: count=0, zero=1, tc=0, busy=0. Pulsing enable=1 for 5 cycles changes nothing.
- One-shot: load data_in=13, mode=0, then enable=1 continuously -> count 13,12,...,1,0 over 13 enabled edges. tc=1 in exactly the single cycle count first reads 0. busy falls on that same edge and count stays 0 afterwards.
- Periodic with stalls: load data_in=3, mode=1, enable toggling 1,0,1,... -> count sequence 3,2,1,0,3,2,1,0 advancing only on enabled edges. tc pulses once per period (two pulses over eight enabled edges), each exactly one cycle wide and never during a stall.
- Reload mid-run: load 13, count down to 9, then load 5 with mode=0 -> next count=5 with no tc. Reaches 0 after 5 further enabled edges with one tc.
- Zero load and load/terminal collision: load data_in=0 -> busy=0, tc=0, zero=1. Then load 2 and count to 1; assert load with data_in=7 on the edge that would reach 0 -> count=7, tc stays 0.
- Reset mid-operation: periodic load 15, run to count 6, assert reset for one cycle with load=1 and enable=1 -> count=0, busy=0, tc=0. Reset overrides load.
